// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the write-back port arbiter and the FU cluster around it.
// fu_output_t and completion_port_t are the cluster-wide result and ROB
// completion formats; the arbiter passes them through untouched.
package wb_port_arbiter_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned ROB_ID_W         = 6;
    localparam int unsigned EX_CAUSE_W       = 5;

    // Number of functional units that share one write-back port by default.
    localparam int unsigned NR_WB_SHARED_REQ = 3;

    typedef logic [NR_WB_SHARED_REQ-1:0] wb_req_bitvector_t;

    // Result produced by a functional unit.
    typedef struct packed {
        logic [ROB_ID_W-1:0]   id;
        logic [XLEN-1:0]       result;
        logic                  ex_valid;
        logic [EX_CAUSE_W-1:0] ex_cause;
    } fu_output_t;

    // Completion notification towards the ROB.
    typedef struct packed {
        logic                valid;
        logic [ROB_ID_W-1:0] id;
    } completion_port_t;

    // Round-robin successor of index g among n requesters.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return ((g + 1) >= n) ? 0 : (g + 1);
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Small per-requester result FIFO. Registered occupancy count, naturally
// wrapping read/write pointers, synchronous flush that drops everything
// including a push presented in the same cycle. No pass-through: data
// written in one cycle is visible at the head from the next cycle on.
module wb_arb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic [7:0]
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         push,
    input  T                             din,
    input  logic                         pop,
    output T                             head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= din;
        end
    end

    assign head  = mem[rptr_q];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    // The producer may only push when there is room.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rstn)
        !(push && (cnt_q == CNT_W'(DEPTH))));

    // The arbiter never grants an empty FIFO.
    a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!rstn)
        !(pop && (cnt_q == '0)));

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one write-back / ROB completion port between NR_REQ functional
// units. Every FU feeds a small FIFO; a round-robin arbiter drains at most one
// result per cycle into a registered output stage.
//
// Handshake: on each FU input a result transfers on a rising edge where
// req_valid_i[i] and req_ready_o[i] are both high. req_ready_o depends only on
// registered state, never on req_valid_i. An FU that sees valid without ready
// must hold its payload stable until the transfer. The shared output has no
// ready: wb_valid_o marks a one-cycle result that the consumer must take.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned NR_REQ = NR_WB_SHARED_REQ,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  fu_output_t           req_data_i [NR_REQ],
    input  logic [NR_REQ-1:0]    req_valid_i,
    output logic [NR_REQ-1:0]    req_ready_o,
    input  logic                 flush_i,
    output fu_output_t           wb_o,
    output logic                 wb_valid_o,
    output completion_port_t     compl_o
);

    localparam int unsigned PTR_W = $clog2(NR_REQ);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // High from the first clock edge after reset release; keeps the inputs
    // not-ready while reset is asserted.
    logic               active_q;

    logic [PTR_W-1:0]   rr_ptr_q;

    logic [NR_REQ-1:0]  push;
    logic [NR_REQ-1:0]  pop;
    logic [NR_REQ-1:0]  fifo_empty;
    logic [CNT_W-1:0]   fifo_count [NR_REQ];
    fu_output_t         fifo_head  [NR_REQ];

    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    fu_output_t         grant_data;

    fu_output_t         wb_q;
    logic               wb_valid_q;

    // Track whether the block has left reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    // Ready per FU: room in its FIFO, judged from the registered count only.
    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < int'(NR_REQ); i++) begin
            req_ready_o[i] = active_q && (fifo_count[i] != CNT_W'(DEPTH));
        end
    end

    assign push = req_valid_i & req_ready_o;

    for (genvar i = 0; i < NR_REQ; i++) begin : g_fifo
        wb_arb_fifo #(
            .DEPTH (DEPTH),
            .T     (fu_output_t)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .flush (flush_i),
            .push  (push[i]),
            .din   (req_data_i[i]),
            .pop   (pop[i]),
            .head  (fifo_head[i]),
            .empty (fifo_empty[i]),
            .count (fifo_count[i])
        );
    end

    // Round-robin search over non-empty FIFOs starting at the pointer;
    // nothing is granted in a flush cycle.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        for (int unsigned k = 0; k < NR_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NR_REQ) begin
                idx = idx - NR_REQ;
            end
            if (!grant_valid && !fifo_empty[PTR_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
                grant_data  = fifo_head[PTR_W'(idx)];
            end
        end
        if (flush_i) begin
            grant_valid = 1'b0;
        end
    end

    // A grant always pops: the shared port cannot stall.
    always_comb begin
        pop = '0;
        if (grant_valid) begin
            pop[grant_idx] = 1'b1;
        end
    end

    // Advance the pointer past the winner; hold it when nothing is granted.
    // A flush leaves the pointer alone.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
        end else if (grant_valid) begin
            rr_ptr_q <= PTR_W'(rr_next(32'(grant_idx), NR_REQ));
        end
    end

    // Output register; the payload holds its last value while not valid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_q       <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            wb_valid_q <= grant_valid;
            if (grant_valid) begin
                wb_q <= grant_data;
            end
        end
    end

    assign wb_o       = wb_q;
    assign wb_valid_o = wb_valid_q;

    // ROB completion mirrors the output register.
    always_comb begin
        compl_o       = '0;
        compl_o.valid = wb_valid_q;
        compl_o.id    = wb_q.id;
    end

    a_single_grant : assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(pop));

    a_ptr_in_range : assert property (@(posedge clk) disable iff (!rstn)
        (32'(rr_ptr_q) < NR_REQ));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a table of hand-computed per-cycle vectors on a
// 3-requester instance, then a random soak on a 4-requester instance checked
// by per-requester expected queues.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int unsigned N3    = 3;
    localparam int unsigned N4    = 4;
    localparam int unsigned DEPTH = 2;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 3-requester DUT ----------------
    logic             rstn;
    fu_output_t       req_data [N3];
    logic [N3-1:0]    req_valid;
    logic [N3-1:0]    req_ready;
    logic             flush;
    fu_output_t       wb;
    logic             wb_valid;
    completion_port_t compl;

    wb_port_arbiter #(.NR_REQ(N3), .DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .flush_i     (flush),
        .wb_o        (wb),
        .wb_valid_o  (wb_valid),
        .compl_o     (compl)
    );

    // ---------------- 4-requester DUT ----------------
    logic             rstn4;
    fu_output_t       req_data4 [N4];
    logic [N4-1:0]    req_valid4;
    logic [N4-1:0]    req_ready4;
    logic             flush4;
    fu_output_t       wb4;
    logic             wb_valid4;
    completion_port_t compl4;

    wb_port_arbiter #(.NR_REQ(N4), .DEPTH(DEPTH)) u_dut4 (
        .clk         (clk),
        .rstn        (rstn4),
        .req_data_i  (req_data4),
        .req_valid_i (req_valid4),
        .req_ready_o (req_ready4),
        .flush_i     (flush4),
        .wb_o        (wb4),
        .wb_valid_o  (wb_valid4),
        .compl_o     (compl4)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    function automatic fu_output_t make_fu(input logic [ROB_ID_W-1:0] id);
        fu_output_t f;
        f        = '0;
        f.id     = id;
        f.result = XLEN'(id) * XLEN'(1001);
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic                rstn;
        logic                flush;
        logic [2:0]          valid;
        logic [ROB_ID_W-1:0] id0;
        logic [ROB_ID_W-1:0] id1;
        logic [ROB_ID_W-1:0] id2;
        logic                exp_valid;
        logic [ROB_ID_W-1:0] exp_id;
        logic [2:0]          exp_ready;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic r, input logic f, input logic [2:0] v,
                       input int i0, input int i1, input int i2,
                       input logic ev, input int eid, input logic [2:0] er);
        vec_t t;
        t.rstn      = r;
        t.flush     = f;
        t.valid     = v;
        t.id0       = ROB_ID_W'(i0);
        t.id1       = ROB_ID_W'(i1);
        t.id2       = ROB_ID_W'(i2);
        t.exp_valid = ev;
        t.exp_id    = ROB_ID_W'(eid);
        t.exp_ready = er;
        vecs.push_back(t);
    endtask

    // ---------------- soak scoreboard ----------------
    logic [ROB_ID_W-1:0] exp_q0 [$];
    logic [ROB_ID_W-1:0] exp_q1 [$];
    logic [ROB_ID_W-1:0] exp_q2 [$];
    logic [ROB_ID_W-1:0] exp_q3 [$];

    function automatic int q_size(input int r);
        case (r)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            2:       return exp_q2.size();
            default: return exp_q3.size();
        endcase
    endfunction

    task automatic q_push(input int r, input logic [ROB_ID_W-1:0] id);
        case (r)
            0:       exp_q0.push_back(id);
            1:       exp_q1.push_back(id);
            2:       exp_q2.push_back(id);
            default: exp_q3.push_back(id);
        endcase
    endtask

    function automatic logic [ROB_ID_W-1:0] q_pop(input int r);
        case (r)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            2:       return exp_q2.pop_front();
            default: return exp_q3.pop_front();
        endcase
    endfunction

    logic [3:0]          seq      [N4];
    logic [N4-1:0]       pushed;
    int                  pend     [N4];
    int                  wait_c   [N4];
    int                  max_gap;
    int                  out_r;
    logic [ROB_ID_W-1:0] exp_id;

    // ---------------- stimulus ----------------
    initial begin
        rstn       = 1'b0;
        flush      = 1'b0;
        req_valid  = '0;
        rstn4      = 1'b0;
        flush4     = 1'b0;
        req_valid4 = '0;
        for (int i = 0; i < int'(N3); i++) req_data[i]  = '0;
        for (int i = 0; i < int'(N4); i++) req_data4[i] = '0;

        //   rstn flush valid  id0 id1 id2  exp_v exp_id exp_ready
        // reset and release
        add(0, 0, 3'b000,  0,  0,  0,   0,  0, 3'b000);
        add(0, 0, 3'b000,  0,  0,  0,   0,  0, 3'b000);
        add(1, 0, 3'b000,  0,  0,  0,   0,  0, 3'b111);
        // contention from pointer 0: 10,20,30 then again 11,21,31
        add(1, 0, 3'b111, 10, 20, 30,   0,  0, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 10, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 20, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 30, 3'b111);
        add(1, 0, 3'b111, 11, 21, 31,   0, 30, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 11, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 21, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 31, 3'b111);
        // single push on requester 1, two-cycle latency, one cycle valid
        add(1, 0, 3'b010,  0,  5,  0,   0, 31, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1,  5, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   0,  5, 3'b111);
        // backpressure: req0 sends 1,2,3 against req2 traffic (pointer at 2)
        add(1, 0, 3'b101,  1,  0, 40,   0,  5, 3'b111);
        add(1, 0, 3'b101,  2,  0, 41,   1, 40, 3'b110);
        add(1, 0, 3'b101,  3,  0, 42,   1,  1, 3'b011);
        add(1, 0, 3'b101,  3,  0, 43,   1, 41, 3'b110);
        add(1, 0, 3'b100,  0,  0, 43,   1,  2, 3'b011);
        add(1, 0, 3'b000,  0,  0,  0,   1, 42, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1,  3, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 43, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   0, 43, 3'b111);
        // flush with 7,8 buffered and 9 pushed in the flush cycle
        add(1, 0, 3'b001,  6,  0,  0,   0, 43, 3'b111);
        add(1, 0, 3'b011,  7,  8,  0,   1,  6, 3'b111);
        add(1, 1, 3'b010,  0,  9,  0,   0,  6, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   0,  6, 3'b111);
        // pointer kept at 1 across the flush
        add(1, 0, 3'b111, 60, 61, 62,   0,  6, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 61, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 62, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 60, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   0, 60, 3'b111);
        // reset mid-operation with FIFOs 0 and 2 full
        add(1, 0, 3'b111, 44, 45, 46,   0, 60, 3'b111);
        add(1, 0, 3'b111, 47, 48, 49,   1, 45, 3'b010);
        add(0, 0, 3'b111,  1,  1,  1,   0,  0, 3'b000);
        add(1, 0, 3'b000,  0,  0,  0,   0,  0, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   0,  0, 3'b111);
        // pointer back at 0 after reset
        add(1, 0, 3'b111, 56, 57, 58,   0,  0, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 56, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 57, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   1, 58, 3'b111);
        add(1, 0, 3'b000,  0,  0,  0,   0, 58, 3'b111);

        for (int n = 0; n < vecs.size(); n++) begin
            vec_t v;
            v           = vecs[n];
            rstn        = v.rstn;
            flush       = v.flush;
            req_valid   = v.valid;
            req_data[0] = make_fu(v.id0);
            req_data[1] = make_fu(v.id1);
            req_data[2] = make_fu(v.id2);
            tick();
            check($sformatf("v%0d wb_valid", n), 64'(wb_valid), 64'(v.exp_valid));
            check($sformatf("v%0d wb_o", n), 64'(wb), 64'(make_fu(v.exp_id)));
            check($sformatf("v%0d compl", n), 64'(compl), 64'({v.exp_valid, v.exp_id}));
            check($sformatf("v%0d ready", n), 64'(req_ready), 64'(v.exp_ready));
        end
        req_valid = '0;

        // ---------------- soak on the 4-requester instance ----------------
        max_gap = 0;
        for (int r = 0; r < int'(N4); r++) begin
            seq[r]    = '0;
            wait_c[r] = 0;
        end
        tick();
        rstn4 = 1'b1;
        tick();
        check("soak ready after reset", 64'(req_ready4), 64'(4'b1111));

        for (int cyc = 0; cyc < 1030; cyc++) begin
            for (int r = 0; r < int'(N4); r++) begin
                pend[r] = q_size(r);
                if (cyc < 1000 && !req_valid4[r] && $urandom_range(0, 9) < 7) begin
                    req_valid4[r] = 1'b1;
                    req_data4[r]  = make_fu({2'(r), seq[r]});
                    seq[r]        = seq[r] + 4'd1;
                end
            end
            pushed = req_valid4 & req_ready4;
            tick();
            out_r = -1;
            if (wb_valid4) begin
                out_r = int'(wb4.id[5:4]);
                checks++;
                if (q_size(out_r) == 0) begin
                    errors++;
                    $display("FAIL soak unexpected: got id 0x%0h expected nothing from req %0d", wb4.id, out_r);
                end else begin
                    exp_id = q_pop(out_r);
                    check("soak wb_o", 64'(wb4), 64'(make_fu(exp_id)));
                    check("soak compl", 64'(compl4), 64'({1'b1, exp_id}));
                end
            end
            for (int r = 0; r < int'(N4); r++) begin
                if (out_r == r) begin
                    wait_c[r] = 0;
                end else if (pend[r] > 0) begin
                    wait_c[r]++;
                    if (wait_c[r] > max_gap) max_gap = wait_c[r];
                end else begin
                    wait_c[r] = 0;
                end
                if (pushed[r]) begin
                    q_push(r, req_data4[r].id);
                    req_valid4[r] = 1'b0;
                end
            end
        end

        for (int r = 0; r < int'(N4); r++) begin
            check($sformatf("soak drained req%0d", r), 64'(q_size(r)), 64'd0);
        end
        check("soak idle valid", 64'(wb_valid4), 64'd0);
        checks++;
        if (max_gap > int'(N4)) begin
            errors++;
            $display("FAIL soak fairness: got max gap %0d expected at most %0d", max_gap, N4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares one write-back/completion port between NR_REQ functional units, e.g. the CSR/misc unit and the divider. This removes the fixed one-FU-per-WB-port mapping in the FU cluster.
- Each requester gets a small FIFO that absorbs results, so multi-cycle FUs can hand off without stalling.
- A round-robin arbiter drains one result per cycle onto the shared port.
- Sits between the FU outputs and the register-file write-back / ROB completion ports.

Parameters:
- NR_REQ, 3, number of FUs sharing the port (2..8).
- DEPTH, 2, entries per requester FIFO (power of 2, >=2).

Ports:
- clk  in  1  core clock.
- rstn  in  1  synchronous active-low reset.
- req_data_i  in  fu_output_t [NR_REQ]  result from each FU.
- req_valid_i  in  NR_REQ  result valid per FU.
- req_ready_o  out  NR_REQ  FIFO can accept per FU.
- flush_i  in  1  squash: discard all buffered results.
- wb_o  out  fu_output_t  shared write-back payload.
- wb_valid_o  out  1  write-back valid.
- compl_o  out  completion_port_t  completion for ROB; id = wb_o.id, valid = wb_valid_o.

Behaviour:
- Reset (rstn=0 at posedge):
  - all FIFOs empty; RR pointer = 0.
  - wb_o = '0, wb_valid_o = 0.
  - req_ready_o = 0 while rstn=0, all 1 on the first cycle after release.
- Per-requester FIFO:
  - req_ready_o[i] = (count[i] != DEPTH), derived from registered count only.
  - A full FIFO is not ready even if it pops in the same cycle; there is no pass-through.
  - Push when req_valid_i[i] & req_ready_o[i]. Pop when granted.
  - Push and pop in the same cycle leaves count unchanged.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - Data pushed at cycle t is eligible for arbitration at t+1.
- Arbiter:
  - Combinational round-robin over non-empty FIFOs, starting at RR pointer.
  - At most one grant per cycle.
  - On grant of index g: RR pointer <= (g+1) mod NR_REQ. With no grant, the pointer holds.
  - The shared port has no backpressure, so a grant always pops.
- Output register:
  - wb_o <= head of granted FIFO; wb_valid_o <= 1 if any grant, else 0.
  - wb_o holds its last value when invalid.
  - Latency: input accepted at t -> wb_valid_o at t+2 (empty arbiter, no contention).
  - Throughput: 1 result/cycle sustained.
- Flush (flush_i=1 at posedge):
  - all FIFO counts/pointers cleared.
  - pushes in the flush cycle dropped.
  - no grant that cycle; wb_valid_o = 0 the following cycle.
  - RR pointer retained.
  - A result already in wb_o when flush rises still presents for its one cycle. The ROB discards it by id.
- compl_o is purely combinational from the output register.
- Fairness: with all FIFOs continuously non-empty, each requester is granted exactly once every NR_REQ cycles.
- Overflow is impossible by construction. Assertion: push while full never occurs (valid without ready is legal; the FU holds).

Decomposition:
- Shared package C:
  - NR_WB_SHARED_REQ constant.
  - wb_req_bitvector_t (logic [NR_REQ-1:0]).
  - fu_output_t and completion_port_t reused unchanged.
- One sub-module, wb_arb_fifo:
  - parameterised DEPTH and type.
  - push/pop/flush, full/empty/count, head data.
  - instantiated NR_REQ times.
- The round-robin grant logic stays inline in the top module.

Test Plan:
- Single push: req 1 valid at t with id=5, others idle -> wb_valid_o=1, wb_o.id=5, compl_o.valid=1 at t+2, one cycle only.
- Contention: all 3 FIFOs loaded with ids {10,20,30} in the same cycle, pointer=0 -> ids 10, 20, 30 on consecutive cycles; pointer ends at 0.
- Backpressure: req 0 pushes ids 1,2,3 on back-to-back cycles while req 2 keeps FIFO 2 non-empty (ids 40,41,42, ...), so req 0 is granted only every other cycle:
  - req_ready_o[0] = 0 on the cycle after FIFO 0 holds 2 entries.
  - id 3 is accepted only after a pop.
  - output order for req 0 is 1,2,3 with nothing lost or duplicated.
- Flush: FIFOs hold ids 7 and 8, flush_i pulsed for 1 cycle while req 1 pushes id 9 -> ids 7, 8, 9 never appear after the flush; all req_ready_o=1 next cycle.
- Reset mid-operation: rstn low for 1 cycle with full FIFOs -> wb_valid_o=0 and wb_o='0 next cycle, all FIFOs empty, pointer=0.
- Fairness soak: 1000 cycles of random valids with NR_REQ=4 -> a scoreboard confirms per-requester in-order delivery, no drops, and max grant gap <= NR_REQ while non-empty.
